// File: rtl/bf_input_fifo_if.sv
// -----------------------------------------------------------------------------
// bf_input_fifo_if
// Host-side byte stream bundle feeding bf_input_fifo.
//   in_valid : host byte valid
//   in_data  : host byte
//   in_ready : buffer can take a byte this cycle
//   in_eof   : end-of-stream flag (pulse or level)
// master = host (drives bytes), slave = buffer.
// -----------------------------------------------------------------------------
interface bf_input_fifo_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       in_eof;

   modport master (
      output in_valid,
      output in_data,
      output in_eof,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_eof,
      output in_ready
   );
endinterface

// File: rtl/bf_input_fifo.sv
// -----------------------------------------------------------------------------
// bf_input_fifo
// Byte buffer in front of the BFCPU ',' port. The host pushes bytes through
// the host interface; each edge on IR is one CPU read request, answered by
// loading INPD with {8'h00, byte}, or with EOF_CODE once the buffer is empty
// and end-of-stream has been flagged. A request that cannot be answered yet
// raises stall until a byte or end-of-stream shows up.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   host   : byte stream in (in_valid/in_data/in_ready/in_eof)
//   IR     : request toggle from the CPU
//   INPD   : answer to the most recent request
//   stall  : request pending with nothing to serve it
//   level  : current occupancy, 0..DEPTH
//   err    : sticky, a request arrived while one was still pending
//
// Parameters:
//   DEPTH    : entries, power of two, >= 2
//   EOF_CODE : value placed on INPD for requests served after end-of-stream
// -----------------------------------------------------------------------------
module bf_input_fifo #(
   parameter int          DEPTH    = 16,
   parameter logic [15:0] EOF_CODE = 16'hFFFF
) (
   input  logic                   clk,
   input  logic                   reset,
   bf_input_fifo_if.slave         host,
   input  logic                   IR,
   output logic [15:0]            INPD,
   output logic                   stall,
   output logic [$clog2(DEPTH):0] level,
   output logic                   err
);

   localparam int AW = $clog2(DEPTH);   // address bits
   localparam int PW = AW + 1;          // pointer bits, MSB is the wrap bit

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t         state_reg, state_next;
   logic [PW-1:0]  wp_reg, wp_next;
   logic [PW-1:0]  rp_reg, rp_next;
   logic           eof_reg, eof_next;
   logic           ir_reg;
   logic           stall_reg, stall_next;
   logic           err_reg, err_next;
   logic [15:0]    inpd_reg;

   logic [7:0]     mem [DEPTH];

   logic           empty;
   logic           full;
   logic           req;
   logic           push;
   logic           pop;
   logic           load_eof;

   // Status derives only from registered pointers, so a pop in the cycle the
   // buffer is full frees a slot for the host one cycle later.
   assign empty = (wp_reg == rp_reg);
   assign full  = (wp_reg[AW] != rp_reg[AW]) &&
                  (wp_reg[AW-1:0] == rp_reg[AW-1:0]);

   // Any edge of IR, rising or falling, is a request.
   assign req = (IR != ir_reg);

   // -------------------------------------------------------------------------
   // Next-state and control
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      stall_next = stall_reg;
      err_next   = err_reg;
      pop        = 1'b0;
      load_eof   = 1'b0;
      eof_next   = eof_reg | host.in_eof;
      push       = host.in_valid && !full;

      case (state_reg)
         ST_IDLE: begin
            if (req) begin
               if (!empty) begin
                  pop = 1'b1;
               end else if (eof_reg) begin
                  load_eof = 1'b1;
               end else begin
                  state_next = ST_WAIT;
                  stall_next = 1'b1;
               end
            end
         end

         ST_WAIT: begin
            // A second request while waiting is folded into the pending one;
            // only the error flag records that it happened.
            if (req) begin
               err_next = 1'b1;
            end
            // Decided on registered pointers: a byte pushed at edge m is
            // served at edge m+1, never bypassed within the push cycle.
            if (!empty) begin
               pop        = 1'b1;
               stall_next = 1'b0;
               state_next = ST_IDLE;
            end else if (eof_reg) begin
               load_eof   = 1'b1;
               stall_next = 1'b0;
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      wp_next = wp_reg + {{AW{1'b0}}, push};
      rp_next = rp_reg + {{AW{1'b0}}, pop};
   end

   // -------------------------------------------------------------------------
   // Storage write port. Contents are not reset; the pointers define what is
   // valid.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp_reg[AW-1:0]] <= host.in_data;
      end
   end

   // -------------------------------------------------------------------------
   // State, pointers and answer register. INPD is the registered read port of
   // the storage array, so there is no combinational path from IR to INPD.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         wp_reg    <= '0;
         rp_reg    <= '0;
         eof_reg   <= 1'b0;
         // Track IR through reset so toggles during reset are not seen as
         // requests afterwards.
         ir_reg    <= IR;
         stall_reg <= 1'b0;
         err_reg   <= 1'b0;
         inpd_reg  <= 16'h0000;
      end else begin
         state_reg <= state_next;
         wp_reg    <= wp_next;
         rp_reg    <= rp_next;
         eof_reg   <= eof_next;
         ir_reg    <= IR;
         stall_reg <= stall_next;
         err_reg   <= err_next;
         if (pop) begin
            inpd_reg <= {8'h00, mem[rp_reg[AW-1:0]]};
         end else if (load_eof) begin
            inpd_reg <= EOF_CODE;
         end
      end
   end

   assign INPD          = inpd_reg;
   assign stall         = stall_reg;
   assign err           = err_reg;
   assign level         = wp_reg - rp_reg;
   assign host.in_ready = !full;

endmodule

// File: tb/tb_bf_input_fifo.sv
// -----------------------------------------------------------------------------
// tb_bf_input_fifo
// Directed scenarios followed by a random phase. A queue-based reference
// model predicts every output after every clock edge; key scenario values are
// also checked against fixed constants.
// -----------------------------------------------------------------------------
module tb_bf_input_fifo;

   localparam int DEPTH = 16;
   localparam logic [15:0] EOF_VAL = 16'hFFFF;

   logic        clk;
   logic        reset;
   logic        IR;
   logic [15:0] INPD;
   logic        stall;
   logic [4:0]  level;
   logic        err;

   bf_input_fifo_if hif ();

   bf_input_fifo #(
      .DEPTH    (DEPTH),
      .EOF_CODE (EOF_VAL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .host  (hif),
      .IR    (IR),
      .INPD  (INPD),
      .stall (stall),
      .level (level),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   logic [7:0]  q[$];
   bit          m_eof;
   bit          m_pend;
   bit          m_err;
   bit          m_served;
   logic [15:0] m_inpd;
   logic        prev_ir;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs as they stand now.
   task automatic model_edge();
      bit r;
      bit push_ok;
      m_served = 1'b0;
      if (reset) begin
         q.delete();
         m_eof  = 1'b0;
         m_pend = 1'b0;
         m_err  = 1'b0;
         m_inpd = 16'h0000;
      end else begin
         r       = (IR !== prev_ir);
         push_ok = hif.in_valid && (q.size() < DEPTH);
         if (r || m_pend) begin
            if (r && m_pend) m_err = 1'b1;
            if (q.size() > 0) begin
               m_inpd   = {8'h00, q.pop_front()};
               m_pend   = 1'b0;
               m_served = 1'b1;
            end else if (m_eof) begin
               m_inpd   = EOF_VAL;
               m_pend   = 1'b0;
               m_served = 1'b1;
            end else begin
               m_pend = 1'b1;
            end
         end
         if (push_ok) q.push_back(hif.in_data);
         if (hif.in_eof) m_eof = 1'b1;
      end
      prev_ir = IR;
   endtask

   task automatic check_all();
      chk("INPD",     {16'h0, INPD},   {16'h0, m_inpd});
      chk("stall",    {31'h0, stall},  {31'h0, m_pend});
      chk("err",      {31'h0, err},    {31'h0, m_err});
      chk("level",    {27'h0, level},  q.size());
      chk("in_ready", {31'h0, hif.in_ready}, {31'h0, (q.size() < DEPTH)});
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
      if (m_served) $display("[%0t] serve INPD=%h level=%0d", $time, INPD, level);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      hif.in_valid = 1'b1;
      hif.in_data  = b;
      tick();
      hif.in_valid = 1'b0;
   endtask

   int  nxt;
   bit  acc;

   initial begin
      reset        = 1'b1;
      IR           = 1'b0;
      prev_ir      = 1'b0;
      hif.in_valid = 1'b0;
      hif.in_data  = 8'h00;
      hif.in_eof   = 1'b0;
      m_inpd       = 16'h0000;

      // Reset state
      do_reset(2);
      chk("rst_INPD",  {16'h0, INPD}, 32'h0);
      chk("rst_ready", {31'h0, hif.in_ready}, 32'h1);
      chk("rst_level", {27'h0, level}, 32'h0);

      // Basic serve
      push_byte(8'h41);
      push_byte(8'h42);
      chk("basic_level2", {27'h0, level}, 32'd2);
      IR = ~IR; tick();
      chk("basic_first", {16'h0, INPD}, 32'h0041);
      chk("basic_level1", {27'h0, level}, 32'd1);
      repeat (3) tick();
      IR = ~IR; tick();
      chk("basic_second", {16'h0, INPD}, 32'h0042);
      chk("basic_level0", {27'h0, level}, 32'd0);

      // Stall path
      IR = ~IR; tick();
      chk("stall_rise", {31'h0, stall}, 32'h1);
      repeat (2) tick();
      push_byte(8'h7A);
      chk("stall_held", {31'h0, stall}, 32'h1);
      tick();
      chk("stall_data", {16'h0, INPD}, 32'h007A);
      chk("stall_fall", {31'h0, stall}, 32'h0);

      // Protocol error: second toggle while waiting
      IR = ~IR; tick();
      IR = ~IR; tick();
      chk("err_set", {31'h0, err}, 32'h1);
      repeat (2) tick();
      push_byte(8'h55);
      tick();
      chk("err_answer", {16'h0, INPD}, 32'h0055);
      push_byte(8'h66);
      repeat (2) tick();
      chk("err_single", {27'h0, level}, 32'd1);
      chk("err_sticky", {31'h0, err}, 32'h1);

      // Reset mid-WAIT
      do_reset(1);
      push_byte(8'h01);
      push_byte(8'h02);
      push_byte(8'h03);
      repeat (3) begin
         IR = ~IR; tick();
      end
      IR = ~IR; tick();
      chk("rw_stall", {31'h0, stall}, 32'h1);
      reset = 1'b1;
      IR = ~IR;
      tick();
      reset = 1'b0;
      repeat (2) tick();
      chk("rw_stall0", {31'h0, stall}, 32'h0);
      chk("rw_level0", {27'h0, level}, 32'h0);
      chk("rw_INPD",   {16'h0, INPD}, 32'h0);
      chk("rw_err",    {31'h0, err}, 32'h0);
      chk("rw_ready",  {31'h0, hif.in_ready}, 32'h1);

      // Full and wrap-around
      do_reset(1);
      nxt = 0;
      hif.in_valid = 1'b1;
      repeat (17) begin
         hif.in_data = nxt[7:0];
         acc = (q.size() < DEPTH);
         tick();
         if (acc) nxt++;
      end
      chk("full_level", {27'h0, level}, 32'd16);
      chk("full_ready", {31'h0, hif.in_ready}, 32'h0);
      for (int i = 0; i < 20; i++) begin
         IR = ~IR;
         hif.in_data  = nxt[7:0];
         hif.in_valid = (nxt < 20);
         acc = hif.in_valid && (q.size() < DEPTH);
         tick();
         if (acc) nxt++;
         chk("wrap_seq", {16'h0, INPD}, i);
      end
      hif.in_valid = 1'b0;
      tick();
      chk("wrap_empty", {27'h0, level}, 32'd0);

      // EOF
      do_reset(1);
      push_byte(8'h0A);
      hif.in_eof = 1'b1; tick(); hif.in_eof = 1'b0;
      IR = ~IR; tick();
      chk("eof_data", {16'h0, INPD}, 32'h000A);
      repeat (2) tick();
      IR = ~IR; tick();
      chk("eof_1", {16'h0, INPD}, 32'hFFFF);
      tick();
      IR = ~IR; tick();
      chk("eof_2", {16'h0, INPD}, 32'hFFFF);
      chk("eof_stall", {31'h0, stall}, 32'h0);

      // Random traffic against the model
      do_reset(1);
      repeat (800) begin
         hif.in_valid = ($urandom_range(0, 2) != 0);
         hif.in_data  = 8'($urandom);
         hif.in_eof   = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 2) == 0) IR = ~IR;
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 1'b0;
      hif.in_valid = 1'b0;
      hif.in_eof   = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
